// File: rtl/cic_pkg.sv
// Shared constants and helpers for the PDM CIC decimator.
// Width of the accumulators follows the usual CIC bit-growth rule.
package cic_pkg;

   localparam int unsigned NUM_CH    = 16;
   localparam int unsigned NUM_LINES = 8;
   localparam int unsigned ORDER     = 4;

   // Accumulator width: one sign bit plus ORDER*log2(DECIM) growth bits
   function automatic int unsigned cic_width(input int unsigned order,
                                             input int unsigned decim);
      return 1 + order * $clog2(decim);
   endfunction

   // Clamp a signed value to the range of an out_w-bit two's complement word
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                     input int unsigned        out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC decimation channel: integrators at the PDM rate, combs at the
// output rate, then arithmetic scaling and saturation to OUT_W bits.
// Build option: define CIC_ROUND_EN to round half up before the shift.
module cic_channel
   import cic_pkg::*;
#(
   parameter int unsigned ORDER = cic_pkg::ORDER,
   parameter int unsigned DECIM = 32,
   parameter int unsigned OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sample_en,
   input  logic                    pdm_bit,
   input  logic                    dump_en,
   output logic signed [OUT_W-1:0] out
);

   localparam int unsigned W     = cic_width(ORDER, DECIM);
   // One guard bit above W so the exact full-scale result (+2^(W-1)) is
   // representable and saturates instead of wrapping to negative full scale.
   localparam int unsigned AW    = W + 1;
   localparam int          SHIFT = int'(W) - int'(OUT_W);

   typedef logic signed [AW-1:0] acc_t;

   acc_t integ     [ORDER];
   acc_t integ_nxt [ORDER];
   acc_t comb_dly  [ORDER];
   acc_t comb_in   [ORDER];
   acc_t comb_out;
   acc_t comb_res;
   logic dump_q;
   logic signed [63:0]      wide;
   logic signed [63:0]      sat;
   logic signed [OUT_W-1:0] out_nxt;

   // Next integrator values: the whole cascade settles in one sample step
   always_comb begin
      acc_t run;
      integ_nxt = '{default: '0};
      run = pdm_bit ? acc_t'(1) : acc_t'(-1);
      for (int unsigned i = 0; i < ORDER; i++) begin
         run          = integ[i] + run;
         integ_nxt[i] = run;
      end
   end

   // Integrator state advances only on this channel's capture edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) integ <= '{default: '0};
      else if (sample_en) integ <= integ_nxt;
   end

   // Comb cascade, differential delay 1, evaluated on the last integrator
   always_comb begin
      acc_t c;
      comb_in = '{default: '0};
      c = integ[ORDER-1];
      for (int unsigned i = 0; i < ORDER; i++) begin
         comb_in[i] = c;
         c          = c - comb_dly[i];
      end
      comb_out = c;
   end

   // Comb delays and result register update once per decimation period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         comb_dly <= '{default: '0};
         comb_res <= '0;
         dump_q   <= 1'b0;
      end else begin
         dump_q <= dump_en;
         if (dump_en) begin
            comb_dly <= comb_in;
            comb_res <= comb_out;
         end
      end
   end

   // Scale the comb result to OUT_W bits and clamp
   always_comb begin
      wide = {{(64-AW){comb_res[AW-1]}}, comb_res};
      if (SHIFT > 0) begin
`ifdef CIC_ROUND_EN
         wide = wide + (64'sd1 <<< (SHIFT - 1));
`endif
         wide = wide >>> SHIFT;
      end else begin
         wide = wide <<< (-SHIFT);
      end
      sat     = sat_signed(wide, OUT_W);
      out_nxt = sat[OUT_W-1:0];
   end

   // Output word is loaded the cycle after the combs run and then held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) out <= '0;
      else if (dump_q) out <= out_nxt;
   end

endmodule

// File: rtl/pdm_cic_main.sv
// Sixteen-channel PDM-to-PCM front end: bit clock generation, dual-edge
// channel capture, decimation timing and the hop strobe.
// Build option: CIC_ROUND_EN (rounding inside each cic_channel).
module pdm_cic_main
   import cic_pkg::*;
#(
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned DECIM   = 32,
   parameter int unsigned ORDER   = cic_pkg::ORDER,
   parameter int unsigned OUT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      clk_out_pdm,
   input  logic [NUM_LINES-1:0]      din,
   output logic                      hop,
   output logic [NUM_CH*OUT_W-1:0]   val_flat
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DC_W  = $clog2(DECIM);

   logic [DIV_W-1:0] div_cnt;
   logic [DC_W-1:0]  dec_cnt;
   logic             tc;
   logic             rise_en;
   logic             fall_en;
   logic             dump_en;
   logic             dump_q;
   logic signed [OUT_W-1:0] val [NUM_CH];

   assign tc      = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign rise_en = tc & ~clk_out_pdm;
   assign fall_en = tc &  clk_out_pdm;

   // Bit clock divider: toggle the PDM clock at each terminal count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt     <= '0;
         clk_out_pdm <= 1'b0;
      end else if (tc) begin
         div_cnt     <= '0;
         clk_out_pdm <= ~clk_out_pdm;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Count PDM periods; flag the comb run after the wrapping period
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_cnt <= '0;
         dump_en <= 1'b0;
      end else begin
         dump_en <= rise_en && (dec_cnt == DC_W'(DECIM - 1));
         if (rise_en) dec_cnt <= dec_cnt + DC_W'(1);
      end
   end

   // hop lines up with the cycle the channel outputs show new samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump_q <= 1'b0;
         hop    <= 1'b0;
      end else begin
         dump_q <= dump_en;
         hop    <= dump_q;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int unsigned LINE = g % NUM_LINES;
      cic_channel #(
         .ORDER (ORDER),
         .DECIM (DECIM),
         .OUT_W (OUT_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .sample_en ((g < NUM_LINES) ? fall_en : rise_en),
         .pdm_bit   (din[LINE]),
         .dump_en   (dump_en),
         .out       (val[g])
      );
      assign val_flat[g*OUT_W +: OUT_W] = val[g];
   end

endmodule

// File: tb/tb_pdm_cic_main.sv
// Self-checking bench for pdm_cic_main. Expected PCM values come from a
// direct FIR form of the CIC response applied to the recorded input bits.
module tb_pdm_cic_main;

   localparam int R   = 32;
   localparam int N   = 4;
   localparam int OW  = 16;
   localparam int SH  = 5;
   localparam int HL  = N * (R - 1) + 1;
   localparam int MAXS = 1024;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [7:0]         din = 8'h00;
   logic               clk_out_pdm;
   logic               hop;
   logic [16*OW-1:0]   val_flat;

   int     tests = 0;
   int     fails = 0;
   int     edge_cnt = 0;
   int     xs [16][MAXS];
   int     ns [16];
   longint h  [HL];

   always #5 clk = ~clk;

   pdm_cic_main #(
      .CLK_DIV (1),
      .DECIM   (R),
      .ORDER   (N),
      .OUT_W   (OW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_out_pdm (clk_out_pdm),
      .din         (din),
      .hop         (hop),
      .val_flat    (val_flat)
   );

   // CIC impulse response: four cascaded length-R boxcars
   task automatic build_h();
      longint tmp [HL];
      foreach (h[i]) h[i] = 0;
      h[0] = 1;
      repeat (N) begin
         for (int n = 0; n < HL; n++) begin
            tmp[n] = 0;
            for (int k = 0; k < R; k++) if (n - k >= 0) tmp[n] += h[n-k];
         end
         h = tmp;
      end
   endtask

   // Expected PCM output from the first cnt samples of channel ch
   function automatic int model(input int ch, input int cnt);
      longint acc = 0;
      for (int j = 0; j < HL; j++)
         if (cnt - 1 - j >= 0) acc += h[j] * xs[ch][cnt-1-j];
`ifdef CIC_ROUND_EN
      acc += 16;
`endif
      acc = acc >>> SH;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return int'(acc);
   endfunction

   function automatic int get_val(input int k);
      logic signed [OW-1:0] v;
      v = val_flat[k*OW +: OW];
      return int'(v);
   endfunction

   function automatic int exp_cnt(input int k, input int m);
      return (k < 8) ? 32 * m - 1 : 32 * m;
   endfunction

   function automatic logic [7:0] rand_din(input int thr);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = ($urandom_range(255) < thr);
      return r;
   endfunction

   function automatic logic hop_due(input int e);
      return (e >= 65) && ((e - 1) % 64 == 0);
   endfunction

   task automatic clear_model();
      foreach (ns[i]) ns[i] = 0;
      edge_cnt = 0;
   endtask

   // Drive din for one clock edge and record what each channel captured
   task automatic step(input logic [7:0] d);
      int ch;
      din = d;
      @(posedge clk);
      edge_cnt++;
      for (int i = 0; i < 8; i++) begin
         ch = (edge_cnt % 2 == 1) ? 8 + i : i;
         if (ns[ch] < MAXS) begin
            xs[ch][ns[ch]] = d[i] ? 1 : -1;
            ns[ch]++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      din   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (clk_out_pdm !== 1'b0) begin fails++; $display("FAIL reset_pdm_clk got %b want 0", clk_out_pdm); end
      tests++;
      if (hop !== 1'b0) begin fails++; $display("FAIL reset_hop got %b want 0", hop); end
      tests++;
      if (val_flat !== '0) begin fails++; $display("FAIL reset_val got %h want 0", val_flat); end
   endtask

   task automatic test_clock();
      do_reset();
      for (int c = 0; c < 200; c++) begin
         step(rand_din(128));
         tests++;
         if (clk_out_pdm !== 1'(edge_cnt % 2)) begin
            fails++; $display("FAIL clock_pdm edge %0d got %b want %0d", edge_cnt, clk_out_pdm, edge_cnt % 2);
         end
         tests++;
         if (hop !== hop_due(edge_cnt)) begin
            fails++; $display("FAIL clock_hop edge %0d got %b want %b", edge_cnt, hop, hop_due(edge_cnt));
         end
      end
   endtask

   task automatic test_full_scale(input logic pos);
      int m, got, req, fs;
      fs = pos ? 32767 : -32768;
      do_reset();
      for (int c = 0; c < 64 * 6 + 1; c++) begin
         step(pos ? 8'hFF : 8'h00);
         if (hop_due(edge_cnt)) begin
            m = (edge_cnt - 1) / 64;
            tests++;
            if (hop !== 1'b1) begin fails++; $display("FAIL full_scale_hop edge %0d got %b want 1", edge_cnt, hop); end
            for (int k = 0; k < 16; k++) begin
               got = get_val(k);
               req = model(k, exp_cnt(k, m));
               tests++;
               if (got !== req) begin fails++; $display("FAIL full_scale_model pos=%b hop %0d ch %0d got %0d want %0d", pos, m, k, got, req); end
               if (m >= 5) begin
                  tests++;
                  if (got !== fs) begin fails++; $display("FAIL full_scale_const pos=%b ch %0d got %0d want %0d", pos, k, got, fs); end
               end
            end
         end
      end
   endtask

   task automatic test_channel_map();
      int m, got, req;
      do_reset();
      for (int c = 0; c < 64 * 6 + 1; c++) begin
         // upcoming edge even = high-phase capture into channels 0..7
         step(((edge_cnt + 1) % 2 == 0) ? 8'h01 : 8'h00);
         if (hop_due(edge_cnt) && ((edge_cnt - 1) / 64 >= 5)) begin
            m = (edge_cnt - 1) / 64;
            for (int k = 0; k < 16; k++) begin
               got = get_val(k);
               req = (k == 0) ? 32767 : -32768;
               tests++;
               if (got !== req) begin fails++; $display("FAIL channel_map hop %0d ch %0d got %0d want %0d", m, k, got, req); end
               req = model(k, exp_cnt(k, m));
               tests++;
               if (got !== req) begin fails++; $display("FAIL channel_map_model hop %0d ch %0d got %0d want %0d", m, k, got, req); end
            end
         end
      end
   endtask

   task automatic test_zero();
      int m, got, tol;
`ifdef CIC_ROUND_EN
      tol = 1;
`else
      tol = 0;
`endif
      do_reset();
      for (int c = 0; c < 64 * 7 + 1; c++) begin
         // line value constant over a PDM period, toggling each period
         step(((edge_cnt / 2) % 2 == 0) ? 8'hFF : 8'h00);
         if (hop_due(edge_cnt) && ((edge_cnt - 1) / 64 >= 5)) begin
            m = (edge_cnt - 1) / 64;
            for (int k = 0; k < 16; k++) begin
               got = get_val(k);
               tests++;
               if (got > tol || got < -tol) begin fails++; $display("FAIL zero_input hop %0d ch %0d got %0d want 0 (+-%0d)", m, k, got, tol); end
            end
         end
      end
   endtask

   task automatic test_random();
      int m, got, req, thr;
      logic [16*OW-1:0] held;
      thr = int'($urandom_range(40, 215));
      do_reset();
      held = '0;
      for (int c = 0; c < 64 * 10 + 1; c++) begin
         step(rand_din(thr));
         if (hop_due(edge_cnt)) begin
            m = (edge_cnt - 1) / 64;
            tests++;
            if (hop !== 1'b1) begin fails++; $display("FAIL random_hop edge %0d got %b want 1", edge_cnt, hop); end
            for (int k = 0; k < 16; k++) begin
               got = get_val(k);
               req = model(k, exp_cnt(k, m));
               tests++;
               if (got !== req) begin fails++; $display("FAIL random_model thr %0d hop %0d ch %0d got %0d want %0d", thr, m, k, got, req); end
            end
            held = val_flat;
         end else begin
            tests++;
            if (hop !== 1'b0) begin fails++; $display("FAIL random_nohop edge %0d got %b want 0", edge_cnt, hop); end
            tests++;
            if (val_flat !== held) begin fails++; $display("FAIL random_hold edge %0d got %h want %h", edge_cnt, val_flat, held); end
         end
      end
   endtask

   task automatic test_mid_reset();
      int seen, got, req;
      do_reset();
      for (int c = 0; c < 100; c++) step(rand_din(200));
      #3;
      reset = 1'b0;
      #1;
      tests++;
      if (val_flat !== '0) begin fails++; $display("FAIL mid_reset_val got %h want 0", val_flat); end
      tests++;
      if (hop !== 1'b0) begin fails++; $display("FAIL mid_reset_hop got %b want 0", hop); end
      tests++;
      if (clk_out_pdm !== 1'b0) begin fails++; $display("FAIL mid_reset_pdm_clk got %b want 0", clk_out_pdm); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();
      seen = -1;
      for (int c = 0; c < 200; c++) begin
         step(rand_din(60));
         if (hop === 1'b1) begin
            seen = edge_cnt;
            break;
         end
      end
      tests++;
      if (seen !== 65) begin fails++; $display("FAIL mid_reset_restart got hop at %0d want 65", seen); end
      if (seen == 65) begin
         for (int k = 0; k < 16; k++) begin
            got = get_val(k);
            req = model(k, exp_cnt(k, 1));
            tests++;
            if (got !== req) begin fails++; $display("FAIL mid_reset_model ch %0d got %0d want %0d", k, got, req); end
         end
      end
   endtask

   initial begin
      build_h();
      test_reset();
      test_clock();
      test_full_scale(1'b1);
      test_full_scale(1'b0);
      test_channel_map();
      test_zero();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
